xspi_fwft_fifo: RTL and testbench

Single-clock first-word-fall-through FIFO built around the team's 1-write/1-read storage array, whose read port is registered (data appears one clock after a read enable and holds while read enable is low). The block owns the write pointer, read pointer, occupancy and prefetch logic that turn that raw memory into a show-ahead queue. It sits between the AHB slave data path and the XSPI controller, buffering write and read data beats.

---
 rtl/xspi_fwft_fifo.sv | 87 ++++++++
 tb/tb_xspi_fwft_fifo.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/xspi_fwft_fifo.sv
// rtl/xspi_fwft_fifo.sv - show-ahead FIFO: pointer/occupancy/prefetch logic around a registered-read 1W1R array
module xspi_fwft_fifo #(
    parameter int PTR_WIDTH  = 3,
    parameter int DATA_WIDTH = 39,
    parameter int AFULL_LVL  = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  afull,
    output logic                  wr_err,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic [PTR_WIDTH:0]    count
);

    localparam int DEPTH = 1 << PTR_WIDTH;
    localparam logic [PTR_WIDTH:0]   MEM_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   AFULL_C  = (PTR_WIDTH+1)'(AFULL_LVL);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = {{(PTR_WIDTH-1){1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [PTR_WIDTH-1:0] wptr_q, wptr_d;
    logic [PTR_WIDTH-1:0] rptr_q, rptr_d;
    logic [PTR_WIDTH:0]   mem_cnt_q, mem_cnt_d;
    logic                 head_valid_q, head_valid_d;
    logic                 wr_err_q, wr_err_d;
    logic                 rd_err_q, rd_err_d;
    logic                 push, pop, fetch;

    // Fetch uses the registered mem_cnt, so a word written this edge is
    // never read at the same edge and the array needs no bypass path.
    always_comb begin
        push         = wr_en & ~full;
        pop          = rd_en & head_valid_q;
        fetch        = (mem_cnt_q != '0) & (~head_valid_q | pop);
        wptr_d       = push  ? wptr_q + PTR_ONE : wptr_q;
        rptr_d       = fetch ? rptr_q + PTR_ONE : rptr_q;
        mem_cnt_d    = mem_cnt_q + {{PTR_WIDTH{1'b0}}, push} - {{PTR_WIDTH{1'b0}}, fetch};
        head_valid_d = fetch ? 1'b1 : (pop ? 1'b0 : head_valid_q);
        wr_err_d     = wr_en & full;
        rd_err_d     = rd_en & ~head_valid_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            mem_cnt_q    <= '0;
            head_valid_q <= 1'b0;
            wr_err_q     <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            mem_cnt_q    <= mem_cnt_d;
            head_valid_q <= head_valid_d;
            wr_err_q     <= wr_err_d;
            rd_err_q     <= rd_err_d;
        end
    end

    // Storage array with registered read port; contents and read register are not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wr_data;
        end
        if (fetch) begin
            rd_data_q <= mem_q[rptr_q];
        end
    end

    assign full     = (mem_cnt_q == MEM_FULL);
    assign count    = mem_cnt_q + {{PTR_WIDTH{1'b0}}, head_valid_q};
    assign afull    = (count >= AFULL_C);
    assign rd_valid = head_valid_q;
    assign rd_data  = rd_data_q;
    assign wr_err   = wr_err_q;
    assign rd_err   = rd_err_q;

endmodule

// File: tb/tb_xspi_fwft_fifo.sv
// tb/tb_xspi_fwft_fifo.sv - directed self-checking bench for xspi_fwft_fifo
module tb_xspi_fwft_fifo;

    localparam int PW = 3;
    localparam int DW = 39;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          rd_en = 1'b0;
    logic          full, afull, wr_err, rd_valid, rd_err;
    logic [DW-1:0] rd_data;
    logic [PW:0]   count;

    int checks = 0;
    int errors = 0;

    xspi_fwft_fifo #(.PTR_WIDTH(PW), .DATA_WIDTH(DW), .AFULL_LVL(7)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_data(wr_data), .full(full), .afull(afull), .wr_err(wr_err),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_afull", afull, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_rd_err", rd_err, 0);
        rst = 1'b0;
        step();

        // single word latency
        wr_en = 1'b1; wr_data = 'h11;
        step();
        wr_en = 1'b0;
        chk("lat_valid_t", rd_valid, 0);
        chk("lat_count_t", count, 1);
        step();
        chk("lat_valid_t1", rd_valid, 1);
        chk("lat_data", rd_data, 'h11);
        chk("lat_count_t1", count, 1);
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("pop1_valid", rd_valid, 0);
        chk("pop1_count", count, 0);

        // fill to capacity
        for (int k = 1; k <= 9; k++) begin
            wr_en = 1'b1; wr_data = DW'(k);
            step();
            chk("fill_count", count, k);
            chk("fill_afull", afull, (k >= 7) ? 1 : 0);
            chk("fill_full", full, (k == 9) ? 1 : 0);
        end
        wr_data = DW'(10);
        step();
        wr_en = 1'b0;
        chk("ovf_wr_err", wr_err, 1);
        chk("ovf_count", count, 9);
        step();
        chk("ovf_wr_err_clr", wr_err, 0);
        for (int k = 1; k <= 9; k++) begin
            chk("drain_valid", rd_valid, 1);
            chk("drain_data", rd_data, k);
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_valid_end", rd_valid, 0);

        // underflow
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
        chk("udf_rd_err", rd_err, 1);
        chk("udf_count", count, 0);
        step();
        chk("udf_rd_err_clr", rd_err, 0);

        // continuous stream with two words held
        wr_en = 1'b1; wr_data = DW'(100);
        step();
        wr_data = DW'(101);
        step();
        chk("stream_pre_count", count, 2);
        for (int i = 0; i < 40; i++) begin
            wr_data = DW'(102 + i);
            rd_en = 1'b1;
            chk("stream_valid", rd_valid, 1);
            chk("stream_data", rd_data, 100 + i);
            chk("stream_count", count, 2);
            step();
        end
        wr_en = 1'b0;
        for (int i = 140; i <= 141; i++) begin
            chk("stream_tail", rd_data, i);
            step();
        end
        rd_en = 1'b0;
        chk("stream_empty", count, 0);

        // full with simultaneous push and pop
        for (int k = 0; k < 9; k++) begin
            wr_en = 1'b1; wr_data = DW'(20 + k);
            step();
        end
        chk("fp_full", full, 1);
        wr_data = DW'('h3F); rd_en = 1'b1;
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("fp_wr_err", wr_err, 1);
        chk("fp_count", count, 8);
        for (int k = 21; k <= 28; k++) begin
            chk("fp_data", rd_data, k);
            rd_en = 1'b1;
            step();
        end
        rd_en = 1'b0;
        chk("fp_empty", count, 0);

        // reset mid-operation
        for (int k = 0; k < 5; k++) begin
            wr_en = 1'b1; wr_data = DW'(50 + k);
            step();
        end
        wr_en = 1'b0;
        chk("mr_pre_count", count, 5);
        rst = 1'b1;
        #1;
        chk("mr_count", count, 0);
        chk("mr_valid", rd_valid, 0);
        chk("mr_full", full, 0);
        step();
        rst = 1'b0;
        wr_en = 1'b1; wr_data = DW'('hAA);
        step();
        wr_en = 1'b0;
        step();
        chk("mr_valid_after", rd_valid, 1);
        chk("mr_data_after", rd_data, 'hAA);
        chk("mr_count_after", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
